// File: rtl/scan_pkg.sv
// Shared state encodings and sizing helpers for the scan sequencer.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

    // At least one bit so a modulus of 1 still yields a legal vector.
    function automatic int cnt_width(input int dwell, input int blank);
        int m;
        int c;
        m = (dwell > blank) ? dwell : blank;
        c = $clog2(m);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/scan_sequencer_counter.sv
// Modulo counter: counts 0..i_last and wraps, flagging the terminal count.
module mod_counter #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    assign o_tc = (r_count == i_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Decoder scan sequencer: steps w through 0..2**N-1, holding en high for
// DWELL cycles then low for BLANK cycles per index; all outputs registered.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int N     = 4,
    parameter int DWELL = 8,
    parameter int BLANK = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         stop,
    input  logic         single,
    output logic [N-1:0] w,
    output logic         en,
    output logic         busy,
    output logic         wrap
);

    localparam int CW = cnt_width(DWELL, BLANK);

    if (DWELL < 1 || BLANK < 1) begin : g_bad_params
        $error("scan_sequencer: DWELL and BLANK must both be >= 1");
    end

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   w_w_nxt;
    logic           w_en_nxt;
    logic           w_busy_nxt;
    logic           w_wrap_nxt;
    logic           r_single;
    logic           w_single_nxt;
    logic [CW-1:0]  w_last;
    logic           w_tc;
    logic           w_cnt_clr;

    // The timer free-runs through ACTIVE/BLANK; its wrap at terminal count
    // coincides with every state change, so it only needs clearing on entry.
    assign w_last    = (r_state == ST_BLANK) ? CW'(BLANK - 1) : CW'(DWELL - 1);
    assign w_cnt_clr = (r_state == ST_IDLE) || stop;

    mod_counter #(.W(CW)) u_timer (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_clr   (w_cnt_clr),
        .i_en    (1'b1),
        .i_last  (w_last),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_w_nxt      = w;
        w_single_nxt = r_single;
        w_wrap_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_w_nxt = '0;
                if (start && !stop) begin
                    w_state_nxt  = ST_ACTIVE;
                    w_single_nxt = single;
                end
            end
            ST_ACTIVE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_w_nxt     = '0;
                end else if (w_tc) begin
                    w_state_nxt = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_w_nxt     = '0;
                end else if (w_tc) begin
                    w_w_nxt = w + 1'b1;
                    if (w == '1) begin
                        w_wrap_nxt  = 1'b1;
                        w_state_nxt = r_single ? ST_IDLE : ST_ACTIVE;
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_w_nxt     = '0;
            end
        endcase
        w_en_nxt   = (w_state_nxt == ST_ACTIVE);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_single <= 1'b0;
            w        <= '0;
            en       <= 1'b0;
            busy     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_single <= w_single_nxt;
            w        <= w_w_nxt;
            en       <= w_en_nxt;
            busy     <= w_busy_nxt;
            wrap     <= w_wrap_nxt;
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer (N=2, DWELL=3, BLANK=1) against a
// cycle-count reference model.
module tb_scan_sequencer;

    localparam int N     = 2;
    localparam int DWELL = 3;
    localparam int BLANK = 1;
    localparam int PER   = DWELL + BLANK;
    localparam int NIDX  = 2 ** N;
    localparam int PASS  = NIDX * PER;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         stop;
    logic         single;
    logic [N-1:0] w;
    logic         en;
    logic         busy;
    logic         wrap;
    logic [NIDX-1:0] y;

    int n_chk;
    int n_fail;

    // Reference model: scan time since acceptance determines everything.
    bit          m_run;
    bit          m_single;
    bit          m_wrap;
    int unsigned m_t;

    logic         prev_en;
    logic [N-1:0] prev_w;

    scan_sequencer #(.N(N), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .stop    (stop),
        .single  (single),
        .w       (w),
        .en      (en),
        .busy    (busy),
        .wrap    (wrap)
    );

    always_comb y = en ? (NIDX'(1) << w) : '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int exp_w();
        return m_run ? int'((m_t / PER) % NIDX) : 0;
    endfunction

    function automatic int exp_en();
        return (m_run && ((m_t % PER) < DWELL)) ? 1 : 0;
    endfunction

    function automatic int exp_pack();
        return (exp_w() << 3) | (exp_en() << 2) | ((m_run ? 1 : 0) << 1) | (m_wrap ? 1 : 0);
    endfunction

    task automatic model_reset();
        m_run    = 1'b0;
        m_single = 1'b0;
        m_wrap   = 1'b0;
        m_t      = 0;
    endtask

    task automatic model_edge(input logic s, input logic p, input logic g);
        if (!m_run) begin
            m_wrap = 1'b0;
            if (s && !p) begin
                m_run    = 1'b1;
                m_t      = 0;
                m_single = g;
            end
        end else if (p) begin
            m_run  = 1'b0;
            m_wrap = 1'b0;
        end else begin
            m_t++;
            m_wrap = ((m_t % PASS) == 0);
            if (m_wrap && m_single) m_run = 1'b0;
        end
    endtask

    // One clock: drive inputs, update model at the edge, compare 1 ns later.
    task automatic step(input logic s, input logic p, input logic g);
        start  = s;
        stop   = p;
        single = g;
        @(posedge clk);
        model_edge(s, p, g);
        #1;
        chk("outputs", int'({w, en, busy, wrap}), exp_pack());
        chk("decoder", int'(y), exp_en() != 0 ? (1 << exp_w()) : 0);
        if ($countones(y) > 1) chk("onehot", $countones(y), 1);
        if (prev_en && en) chk("glitch", int'(w), int'(prev_w));
        prev_en = en;
        prev_w  = w;
        start  = 1'b0;
        stop   = 1'b0;
        single = 1'b0;
    endtask

    typedef struct {
        logic s;
        logic p;
        logic g;
        int   ew;
        logic een;
        logic ebusy;
        logic ewrap;
    } vec_t;

    vec_t tbl[9];
    int   busy_cnt;

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        prev_en = 1'b0;
        prev_w  = '0;
        start   = 1'b0;
        stop    = 1'b0;
        single  = 1'b0;
        reset_n = 1'b0;
        model_reset();

        tbl[0] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};  // start+stop in IDLE
        tbl[1] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};  // stop in IDLE
        tbl[2] = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0};  // start while busy
        tbl[5] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};  // abort
        tbl[8] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'({w, en, busy, wrap}), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].s, tbl[i].p, tbl[i].g);
            chk("table", int'({w, en, busy, wrap}),
                int'({2'(tbl[i].ew), tbl[i].een, tbl[i].ebusy, tbl[i].ewrap}));
        end

        // Continuous scan: wrap only in the first cycle of the second w=0.
        step(1'b1, 1'b0, 1'b0);
        repeat (16) step(1'b0, 1'b0, 1'b0);
        chk("cont_wrap", int'({w, en, wrap}), int'({2'd0, 1'b1, 1'b1}));
        step(1'b0, 1'b0, 1'b0);
        chk("cont_wrap_end", int'(wrap), 0);
        step(1'b0, 1'b1, 1'b0);

        // Single pass: busy for exactly one full pass.
        step(1'b1, 1'b0, 1'b1);
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (!busy) break;
            busy_cnt++;
        end
        chk("single_busy_len", busy_cnt, PASS);
        chk("single_end", int'({w, busy, wrap}), int'({2'd0, 1'b0, 1'b1}));
        step(1'b0, 1'b0, 1'b0);
        chk("single_after", int'({w, busy, wrap}), 0);

        // Abort in the second ACTIVE cycle of w=2.
        step(1'b1, 1'b0, 1'b0);
        repeat (9) step(1'b0, 1'b0, 1'b0);
        chk("abort_pre", int'({w, en}), int'({2'd2, 1'b1}));
        step(1'b0, 1'b1, 1'b0);
        chk("abort", int'({w, en, busy, wrap}), 0);
        chk("abort_y", int'(y), 0);

        // Start while busy at w=1 does not restart the scan.
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("busy_start_w1", int'({w, busy}), int'({2'd1, 1'b1}));
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("busy_start_w2", int'(w), 2);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        chk("busy_start_w3", int'(w), 3);

        // Asynchronous reset mid-scan, away from any clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", int'({w, en, busy, wrap}), 0);
        model_reset();
        prev_en = 1'b0;
        #3;
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        chk("restart_w0", int'({w, en, busy}), int'({2'd0, 1'b1, 1'b1}));
        step(1'b0, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 6) == 0, ($urandom % 25) == 0, $urandom_range(0, 1) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: width of index output w; scan range 0..2**N-1.
REQ-002 SHALL have parameter DWELL, default 8: cycles en is held high per index; legal range >= 1.
REQ-003 SHALL have parameter BLANK, default 2: cycles en is held low between indices; legal range >= 1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  start-scan request, sampled each clk.
REQ-007 stop  input  1  abort request, sampled each clk.
REQ-008 single  input  1  one-pass mode, sampled only in the cycle start is accepted.
REQ-009 w  output  N  index for the downstream N-to-2**N decoder, registered.
REQ-010 en  output  1  decoder enable, registered.
REQ-011 busy  output  1  high in every state except IDLE, registered.
REQ-012 wrap  output  1  one-cycle pulse on completion of a full pass, registered.

Function
REQ-013 SHALL implement states IDLE, ACTIVE and BLANK.
REQ-014 IDLE: en=0, w=0, busy=0; start=1 and stop=0 -> ACTIVE, w=0, latch single, clear dwell counter.
REQ-015 ACTIVE: en=1 for exactly DWELL consecutive cycles, then -> BLANK.
REQ-016 BLANK: en=0 for exactly BLANK cycles, then advance.
REQ-017 Advance from w < 2**N-1: w <= w+1, -> ACTIVE.
REQ-018 Advance from w = 2**N-1 with latched single=0: w wraps to 0, -> ACTIVE, wrap=1 for that one cycle.
REQ-019 Advance from w = 2**N-1 with latched single=1: w <= 0, -> IDLE, wrap=1 for that one cycle.
REQ-020 w SHALL change only on BLANK->ACTIVE or any ->IDLE transitions, never while en=1.
REQ-021 Latency: start accepted at edge k -> en=1, busy=1, w=0 in the cycle after edge k.
REQ-022 Per-index period SHALL be DWELL+BLANK cycles; full pass SHALL be 2**N*(DWELL+BLANK) cycles.
REQ-023 stop=1 in ACTIVE or BLANK -> IDLE at next edge: en=0, w=0, busy=0, wrap=0.
REQ-024 stop and start both high in the same cycle -> stop wins; an IDLE block stays IDLE.
REQ-025 start while busy=1 SHALL be ignored; the scan position is not restarted.
REQ-026 stop in IDLE SHALL have no effect.
REQ-027 Dwell/blank counter width SHALL be clog2(max(DWELL,BLANK)) bits; index arithmetic is modulo 2**N.
REQ-028 Elaboration SHALL fail if DWELL < 1 or BLANK < 1.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, w=0, en=0, busy=0, wrap=0, counter=0, latched single=0, independent of clk.
REQ-030 Reset asserted mid-scan SHALL discard the scan position; the first start after release begins at w=0.
REQ-031 Reset deassertion SHALL take effect on the following rising clk edge.

Structure
REQ-032 State encodings (IDLE, ACTIVE, BLANK) SHALL be constants in shared package scan_pkg; consumers compare against these constants only.
REQ-033 The dwell/blank timer SHALL be one sub-module, mod_counter: parameterised modulus, with clear, enable and terminal-count outputs.
REQ-034 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Verification (N=2, DWELL=3, BLANK=1; bench drives a decoder from w/en and checks that y is one-hot or all-zero)
REQ-035 Reset: reset_n=0 mid-simulation, asynchronously and not on a clk edge -> w=0, en=0, busy=0, wrap=0 before the next clk edge.
REQ-036 Continuous scan: start pulse with single=0 -> en pattern 1,1,1,0 repeating; w sequence 0,1,2,3,0; wrap=1 only in the first cycle of the second w=0.
REQ-037 Single pass: start with single=1 -> busy high exactly 16 cycles; wrap=1 in the first IDLE cycle; w=0 afterwards.
REQ-038 Abort: stop during the second ACTIVE cycle of w=2 -> next cycle en=0, w=0, busy=0; decoder y all-zero.
REQ-039 Contention: start+stop together in IDLE -> stays IDLE; start pulse at w=1 while busy -> sequence continues 2,3 unchanged.
REQ-040 Glitch check across all scenarios: w never changes in a cycle where en=1 before and after the edge.
